// File: rtl/instr_encoder_if.sv
// Request and imem-write signal bundle for instr_encoder.
// The encoder takes the slave view; the request source and the memory take the master view.
interface instr_encoder_if #(
   parameter int ADDR_W = 6
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_class;
   logic [2:0]        req_funct3;
   logic              req_funct7b5;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [31:0]       req_imm;
   logic              imem_we;
   logic              imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  req_valid, req_class, req_funct3, req_funct7b5,
      input  req_rd, req_rs1, req_rs2, req_imm, imem_ready,
      output req_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output req_valid, req_class, req_funct3, req_funct7b5,
      output req_rd, req_rs1, req_rs2, req_imm, imem_ready,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes field-level RV32I requests and streams the words into imem at consecutive addresses.
// One registered write slot; it can be refilled in the same cycle its write completes.
//
// state | meaning
// RUN   | accepting requests and writing words
// FULL  | last address written with WRAP=0; idle until reset or flush
module instr_encoder #(
   parameter int ADDR_W = 6,
   parameter bit WRAP   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   instr_encoder_if.slave  bus,
   output logic [ADDR_W:0] count,
   output logic            full,
   output logic            err
);
   typedef enum logic {RUN, FULL} state_t;

   localparam logic [6:0]        OP_R      = 7'b0110011;
   localparam logic [6:0]        OP_IMM    = 7'b0010011;
   localparam logic [6:0]        OP_LOAD   = 7'b0000011;
   localparam logic [6:0]        OP_STORE  = 7'b0100011;
   localparam logic [6:0]        OP_BRANCH = 7'b1100011;
   localparam logic [6:0]        OP_JAL    = 7'b1101111;
   localparam logic [ADDR_W-1:0] LAST      = '1;
   localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_q, err_d;

   logic [31:0] imm;
   logic [31:0] word;
   logic        bad;
   logic        fits12, fits13, fits21;
   logic        last_hold, ready, accept, complete;

   assign imm    = bus.req_imm;
   assign fits12 = (imm[31:11] == {21{imm[11]}});
   assign fits13 = (imm[31:12] == {20{imm[12]}});
   assign fits21 = (imm[31:20] == {12{imm[20]}});

   always_comb begin
      word = '0;
      bad  = 1'b0;
      case (bus.req_class)
         3'd0: word = {1'b0, bus.req_funct7b5, 5'b0, bus.req_rs2, bus.req_rs1,
                       bus.req_funct3, bus.req_rd, OP_R};
         3'd1: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b101)
               word = {1'b0, bus.req_funct7b5, 5'b0, imm[4:0], bus.req_rs1,
                       bus.req_funct3, bus.req_rd, OP_IMM};
            else
               word = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_IMM};
            bad = !fits12;
         end
         3'd2: begin
            word = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_LOAD};
            bad  = !fits12;
         end
         3'd3: begin
            word = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0], OP_STORE};
            bad  = !fits12;
         end
         3'd4: begin
            word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                    imm[4:1], imm[11], OP_BRANCH};
            bad  = !fits13 || imm[0];
         end
         3'd5: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OP_JAL};
            bad  = !fits21 || imm[0];
         end
         default: bad = 1'b1;
      endcase
   end

   // Without wrap, a word loaded while the last address drains would have nowhere to go.
   assign last_hold = !WRAP && we_q && (addr_q == LAST);
   assign ready     = (state_q == RUN) && (!we_q || bus.imem_ready) && !last_hold && !flush;
   assign accept    = bus.req_valid && ready;
   assign complete  = we_q && bus.imem_ready;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      err_d   = 1'b0;
      if (complete) begin
         we_d   = 1'b0;
         addr_d = addr_q + 1'b1;
         if (count_q != DEPTH)
            count_d = count_q + 1'b1;
         if (addr_q == LAST && !WRAP)
            state_d = FULL;
      end
      if (accept) begin
         if (bad) begin
            err_d = 1'b1;
         end else begin
            we_d    = 1'b1;
            wdata_d = word;
         end
      end
      if (flush) begin
         state_d = RUN;
         we_d    = 1'b0;
         addr_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign count          = count_q;
   assign full           = (state_q == FULL);
   assign err            = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one WRAP=0 and one WRAP=1 instance, depth 4,
// with a write scoreboard per instance checked on every completed imem write.
module tb_instr_encoder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, flush0, flush1;
   logic [2:0] count0, count1;
   logic       full0, full1, err0, err1;

   instr_encoder_if #(.ADDR_W(2)) if0 ();
   instr_encoder_if #(.ADDR_W(2)) if1 ();

   instr_encoder #(.ADDR_W(2), .WRAP(1'b0)) dut0 (
      .clk(clk), .reset(rst0), .flush(flush0), .bus(if0),
      .count(count0), .full(full0), .err(err0));

   instr_encoder #(.ADDR_W(2), .WRAP(1'b1)) dut1 (
      .clk(clk), .reset(rst1), .flush(flush1), .bus(if1),
      .count(count1), .full(full1), .err(err1));

   int vectors = 0;
   int miscompares = 0;
   logic [33:0] sb0[$];
   logic [33:0] sb1[$];
   logic [1:0]  wa0 = 2'd0;
   logic [1:0]  wa1 = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (if0.imem_we === 1'b1 && if0.imem_ready === 1'b1) begin
         if (sb0.size() == 0) chk("dut0_unexpected_write", 32'(sb0.size()), 32'd1);
         else begin
            logic [33:0] e;
            e = sb0.pop_front();
            chk("dut0_addr", 32'(if0.imem_addr), 32'(e[33:32]));
            chk("dut0_wdata", if0.imem_wdata, e[31:0]);
         end
      end
      if (if1.imem_we === 1'b1 && if1.imem_ready === 1'b1) begin
         if (sb1.size() == 0) chk("dut1_unexpected_write", 32'(sb1.size()), 32'd1);
         else begin
            logic [33:0] e;
            e = sb1.pop_front();
            chk("dut1_addr", 32'(if1.imem_addr), 32'(e[33:32]));
            chk("dut1_wdata", if1.imem_wdata, e[31:0]);
         end
      end
   end

   // Drive one request, wait for the handshake, and record the expected write if legal.
   task automatic req(input int sel, input logic [2:0] cls, input logic [2:0] f3,
                      input logic b5, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic ok, input logic [31:0] exp_word);
      logic accepted;
      logic rdy;
      accepted = 1'b0;
      if (sel == 0) begin
         if0.req_class = cls; if0.req_funct3 = f3; if0.req_funct7b5 = b5;
         if0.req_rd = rd; if0.req_rs1 = rs1; if0.req_rs2 = rs2; if0.req_imm = imm;
         if0.req_valid = 1'b1;
      end else begin
         if1.req_class = cls; if1.req_funct3 = f3; if1.req_funct7b5 = b5;
         if1.req_rd = rd; if1.req_rs1 = rs1; if1.req_rs2 = rs2; if1.req_imm = imm;
         if1.req_valid = 1'b1;
      end
      for (int i = 0; i < 20 && !accepted; i++) begin
         rdy = (sel == 0) ? if0.req_ready : if1.req_ready;
         if (rdy === 1'b1) accepted = 1'b1;
         tick();
      end
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      chk("req_accepted", 32'(accepted), 32'd1);
      if (accepted && ok) begin
         if (sel == 0) begin sb0.push_back({wa0, exp_word}); wa0++; end
         else          begin sb1.push_back({wa1, exp_word}); wa1++; end
      end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
      if0.req_valid = 1'b0; if0.imem_ready = 1'b1;
      if0.req_class = '0; if0.req_funct3 = '0; if0.req_funct7b5 = 1'b0;
      if0.req_rd = '0; if0.req_rs1 = '0; if0.req_rs2 = '0; if0.req_imm = '0;
      if1.req_valid = 1'b0; if1.imem_ready = 1'b1;
      if1.req_class = '0; if1.req_funct3 = '0; if1.req_funct7b5 = 1'b0;
      if1.req_rd = '0; if1.req_rs1 = '0; if1.req_rs2 = '0; if1.req_imm = '0;
      repeat (3) tick();
      rst0 = 1'b0; rst1 = 1'b0;

      chk("rst_we", 32'(if0.imem_we), 32'd0);
      chk("rst_addr", 32'(if0.imem_addr), 32'd0);
      chk("rst_wdata", if0.imem_wdata, 32'd0);
      chk("rst_count", 32'(count0), 32'd0);
      chk("rst_full", 32'(full0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_ready", 32'(if0.req_ready), 32'd1);

      // add x3,x1,x2: visible the cycle after the accepting edge
      req(0, 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
      chk("add_we", 32'(if0.imem_we), 32'd1);
      chk("add_addr", 32'(if0.imem_addr), 32'd0);
      chk("add_wdata", if0.imem_wdata, 32'h002081B3);

      // lw x5,8(x0) then sw x5,12(x0) back to back
      req(0, 3'd2, 3'd2, 1'b0, 5'd5, 5'd0, 5'd0, 32'd8, 1'b1, 32'h00802283);
      req(0, 3'd3, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 32'd12, 1'b1, 32'h00502623);
      tick();
      chk("ldst_count", 32'(count0), 32'd3);

      // misaligned branch offset is dropped
      req(0, 3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF9, 1'b0, 32'd0);
      chk("br_err_pulse", 32'(err0), 32'd1);
      chk("br_err_nowe", 32'(if0.imem_we), 32'd0);
      tick();
      chk("br_err_clear", 32'(err0), 32'd0);
      chk("br_err_count", 32'(count0), 32'd3);

      // beq x0,x0,-8 fills the last address
      req(0, 3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b1, 32'hFE000CE3);
      tick();
      chk("full_flag", 32'(full0), 32'd1);
      chk("full_ready", 32'(if0.req_ready), 32'd0);
      chk("full_count", 32'(count0), 32'd4);

      if0.req_class = 3'd0; if0.req_rd = 5'd3; if0.req_rs1 = 5'd1; if0.req_rs2 = 5'd2;
      if0.req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("full_no_accept", 32'(if0.req_ready), 32'd0);
         tick();
      end
      chk("full_count_hold", 32'(count0), 32'd4);

      // flush with a request present: not accepted, state cleared
      flush0 = 1'b1;
      #1;
      chk("flush_ready", 32'(if0.req_ready), 32'd0);
      tick();
      flush0 = 1'b0; if0.req_valid = 1'b0;
      wa0 = 2'd0;
      chk("flush_addr", 32'(if0.imem_addr), 32'd0);
      chk("flush_count", 32'(count0), 32'd0);
      chk("flush_full", 32'(full0), 32'd0);
      chk("flush_we", 32'(if0.imem_we), 32'd0);
      tick();
      chk("flush_no_write", 32'(count0), 32'd0);

      // stall: addi held while a second request (sub) waits
      if0.imem_ready = 1'b0;
      req(0, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
      if0.req_class = 3'd0; if0.req_funct7b5 = 1'b1; if0.req_funct3 = 3'd0;
      if0.req_rd = 5'd5; if0.req_rs1 = 5'd6; if0.req_rs2 = 5'd7;
      if0.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", 32'(if0.req_ready), 32'd0);
         chk("stall_we", 32'(if0.imem_we), 32'd1);
         chk("stall_addr", 32'(if0.imem_addr), 32'd0);
         chk("stall_wdata", if0.imem_wdata, 32'hFFF00093);
         tick();
      end
      if0.imem_ready = 1'b1;
      #1;
      chk("unstall_ready", 32'(if0.req_ready), 32'd1);
      sb0.push_back({wa0, 32'h407302B3}); wa0++;
      tick();
      if0.req_valid = 1'b0;
      chk("unstall_we", 32'(if0.imem_we), 32'd1);
      chk("unstall_addr", 32'(if0.imem_addr), 32'd1);
      chk("unstall_wdata", if0.imem_wdata, 32'h407302B3);

      // error causes
      req(0, 3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
      chk("illegal_class_err", 32'(err0), 32'd1);
      req(0, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
      chk("imm12_range_err", 32'(err0), 32'd1);
      req(0, 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0, 32'd0);
      chk("jal_odd_err", 32'(err0), 32'd1);

      // srai x4,x3,3 and jal x1,+2048
      req(0, 3'd1, 3'd5, 1'b1, 5'd4, 5'd3, 5'd0, 32'd3, 1'b1, 32'h4031D213);
      req(0, 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF);
      chk("jal_err_quiet", 32'(err0), 32'd0);
      repeat (2) tick();
      chk("dut0_final_count", 32'(count0), 32'd4);

      // wrap: fifth word lands at address 0, count saturates
      for (int i = 0; i < 5; i++)
         req(1, 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
      chk("wrap_addr", 32'(if1.imem_addr), 32'd0);
      chk("wrap_we", 32'(if1.imem_we), 32'd1);
      tick();
      chk("wrap_count", 32'(count1), 32'd4);
      chk("wrap_full", 32'(full1), 32'd0);
      chk("wrap_ready", 32'(if1.req_ready), 32'd1);

      // reset during a stall discards the pending word
      if1.imem_ready = 1'b0;
      req(1, 3'd2, 3'd2, 1'b0, 5'd5, 5'd0, 5'd0, 32'd8, 1'b1, 32'h00802283);
      tick();
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      sb1.delete();
      wa1 = 2'd0;
      if1.imem_ready = 1'b1;
      chk("rst_stall_we", 32'(if1.imem_we), 32'd0);
      chk("rst_stall_addr", 32'(if1.imem_addr), 32'd0);
      chk("rst_stall_wdata", if1.imem_wdata, 32'd0);
      chk("rst_stall_count", 32'(count1), 32'd0);
      chk("rst_stall_full", 32'(full1), 32'd0);
      chk("rst_stall_err", 32'(err1), 32'd0);
      repeat (3) tick();
      chk("rst_stall_idle", 32'(if1.imem_we), 32'd0);

      repeat (2) tick();
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
